// File: rtl/phivers_link_pkg.sv
// Shared types for the Phivers link arbiter: flit payload type and arbiter FSM states.
package phivers_link_pkg;

    localparam int FLIT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping at N-1.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 gnt_valid_o
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0] w_idx;

    // Explicit wrap keeps the walk inside 0..N-1 for non-power-of-2 N.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        w_idx       = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid_o && req_i[w_idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = w_idx;
            end
            w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/phivers_link_arbiter.sv
// Packet-level round-robin arbiter sharing one Phivers link between N_SRC sources.
// A grant is held for a whole packet; a watchdog flags an owner that goes quiet mid-packet.
module phivers_link_arbiter
    import phivers_link_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int STALL_MAX = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_SRC-1:0]        tx_i,
    output logic [N_SRC-1:0]        cr_tx_o,
    input  logic [N_SRC-1:0]        eop_tx_i,
    input  logic [N_SRC*FLIT_W-1:0] data_tx_i,
    output logic                    rx_o,
    input  logic                    cr_rx_i,
    output logic                    eop_rx_o,
    output flit_t                   data_rx_o,
    output logic [N_SRC-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    stall_o
);
    localparam int IW = $clog2(N_SRC);
    localparam int CW = $clog2(STALL_MAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_MAX);

    arb_state_e       r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [N_SRC-1:0] r_grant, w_grant_nxt;
    logic [CW-1:0]    r_stall_cnt, w_stall_cnt_nxt;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_valid;
    logic             w_busy;
    logic             w_own_tx;
    logic             w_own_eop;
    logic             w_xfer;
    flit_t            w_own_data;

    rr_arbiter #(
        .N (N_SRC)
    ) u_rr (
        .req_i       (tx_i),
        .ptr_i       (r_ptr),
        .gnt_idx_o   (w_arb_idx),
        .gnt_valid_o (w_arb_valid)
    );

    assign w_busy     = (r_state == ARB_BUSY);
    assign w_own_tx   = tx_i[r_owner];
    assign w_own_eop  = eop_tx_i[r_owner];
    assign w_own_data = data_tx_i[int'(r_owner)*FLIT_W +: FLIT_W];
    assign w_xfer     = w_busy & w_own_tx & cr_rx_i;

    // Zero-latency pass-through from the owner; r_grant is all-zero while idle.
    assign rx_o      = w_busy & w_own_tx;
    assign eop_rx_o  = rx_o & w_own_eop;
    assign data_rx_o = rx_o ? w_own_data : '0;
    assign cr_tx_o   = r_grant & {N_SRC{cr_rx_i}};
    assign grant_o   = r_grant;
    assign busy_o    = w_busy;
    assign stall_o   = w_busy & (r_stall_cnt == CNT_MAX);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_grant_nxt     = r_grant;
        w_stall_cnt_nxt = r_stall_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt     = ARB_BUSY;
                    w_owner_nxt     = w_arb_idx;
                    w_grant_nxt     = N_SRC'(1) << w_arb_idx;
                    w_stall_cnt_nxt = '0;
                end
            end
            ARB_BUSY: begin
                // Pointer moves past the owner so it cannot win the next packet outright.
                if (w_xfer && w_own_eop) begin
                    w_state_nxt     = ARB_IDLE;
                    w_grant_nxt     = '0;
                    w_stall_cnt_nxt = '0;
                    w_ptr_nxt       = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
                end else if (w_own_tx) begin
                    w_stall_cnt_nxt = '0;
                end else if (r_stall_cnt != CNT_MAX) begin
                    w_stall_cnt_nxt = r_stall_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_grant     <= w_grant_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_phivers_link_arbiter.sv
// Bench for phivers_link_arbiter: directed scenarios on a 2-source instance, then a 3-source
// instance with a wrap scenario and randomized traffic against a rule-level reference model.
module tb_phivers_link_arbiter;

    localparam int S2 = 64;
    localparam int S3 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]  tx_a, eop_a, cr_tx_a, grant_a;
    logic [63:0] data_a;
    logic        rx_a, cr_a, eop_rx_a, busy_a, stall_a;
    logic [31:0] data_rx_a;

    logic [2:0]  tx_b, eop_b, cr_tx_b, grant_b;
    logic [95:0] data_b;
    logic        rx_b, cr_b, eop_rx_b, busy_b, stall_b;
    logic [31:0] data_rx_b;

    int n_tests = 0;
    int n_fail  = 0;

    phivers_link_arbiter #(.N_SRC(2), .STALL_MAX(S2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx_a), .cr_tx_o(cr_tx_a), .eop_tx_i(eop_a),
        .data_tx_i(data_a), .rx_o(rx_a), .cr_rx_i(cr_a), .eop_rx_o(eop_rx_a),
        .data_rx_o(data_rx_a), .grant_o(grant_a), .busy_o(busy_a), .stall_o(stall_a)
    );

    phivers_link_arbiter #(.N_SRC(3), .STALL_MAX(S3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx_b), .cr_tx_o(cr_tx_b), .eop_tx_i(eop_b),
        .data_tx_i(data_b), .rx_o(rx_b), .cr_rx_i(cr_b), .eop_rx_o(eop_rx_b),
        .data_rx_o(data_rx_b), .grant_o(grant_b), .busy_o(busy_b), .stall_o(stall_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        tx_a = '0; eop_a = '0; data_a = '0; cr_a = 1'b0;
        tx_b = '0; eop_b = '0; data_b = '0; cr_b = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] fl(input int s, input int p, input int f);
        return {8'(8'hA0 + s), 8'(p), 16'(f)};
    endfunction

    // reference model state for the 3-source instance
    bit          m_busy;
    int          m_own, m_ptr, m_idle;
    bit          has_pkt [3];
    int          idx [3], len [3], pid [3];
    logic        e_rx, e_eop, e_stall, xfer, found;
    logic [31:0] e_data;
    logic [2:0]  e_cr, e_grant;
    int          k, c;

    initial begin
        rst_n = 1'b0;
        tx_a = '0; eop_a = '0; data_a = '0; cr_a = 1'b0;
        tx_b = '0; eop_b = '0; data_b = '0; cr_b = 1'b0;

        // T1: reset with all sources requesting
        tick;
        tx_a = 2'b11; cr_a = 1'b1; data_a = {fl(1, 0, 0), fl(0, 0, 0)};
        settle;
        check("t1_rst_rx", rx_a, 0);
        check("t1_rst_grant", grant_a, 0);
        check("t1_rst_cr", cr_tx_a, 0);
        check("t1_rst_busy", busy_a, 0);
        check("t1_rst_stall", stall_a, 0);
        check("t1_rst_data", data_rx_a, 0);
        tick;
        rst_n = 1'b1;
        settle;
        check("t1_idle_grant", grant_a, 0);
        check("t1_idle_rx", rx_a, 0);
        tick;
        eop_a = 2'b11;
        settle;
        check("t1_grant", grant_a, 2'b01);
        check("t1_rx", rx_a, 1);
        check("t1_data", data_rx_a, fl(0, 0, 0));
        check("t1_cr", cr_tx_a, 2'b01);
        tick;

        // T2: both sources stream 3-flit packets, link always ready
        do_reset;
        tx_a = 2'b11; cr_a = 1'b1;
        for (int p = 0; p < 4; p++) begin
            eop_a = 2'b00;
            settle;
            check("t2_bubble_rx", rx_a, 0);
            check("t2_bubble_busy", busy_a, 0);
            tick;
            for (int f = 0; f < 3; f++) begin
                eop_a  = (f == 2) ? 2'b11 : 2'b00;
                data_a = {fl(1, p, f), fl(0, p, f)};
                settle;
                check("t2_grant", grant_a, 32'(1) << (p % 2));
                check("t2_data", data_rx_a, fl(p % 2, p, f));
                check("t2_eop", eop_rx_a, (f == 2));
                tick;
            end
        end

        // T3: src1 owns, link credit toggles, src0 requests but is ignored
        do_reset;
        tx_a = 2'b10; cr_a = 1'b1;
        settle;
        check("t3_idle_grant", grant_a, 0);
        tick;
        tx_a = 2'b11;
        k = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            cr_a   = (cyc % 2 == 0);
            eop_a  = {(k == 3), 1'b1};
            data_a = {fl(1, 9, k), 32'hDEAD_0000 | 32'(cyc)};
            settle;
            check("t3_rx", rx_a, 1);
            check("t3_data", data_rx_a, fl(1, 9, k));
            check("t3_eop", eop_rx_a, (k == 3));
            check("t3_cr", cr_tx_a, {cr_a, 1'b0});
            check("t3_stall", stall_a, 0);
            tick;
            if (cr_a) k++;
        end
        eop_a = 2'b00; cr_a = 1'b1;
        settle;
        check("t3_done_busy", busy_a, 0);
        check("t3_done_grant", grant_a, 0);
        tick;
        settle;
        check("t3_next_src0", grant_a, 2'b01);

        // T4: owner goes quiet mid-packet, watchdog trips after STALL_MAX idle cycles
        do_reset;
        tx_a = 2'b01; cr_a = 1'b1; data_a = {32'h0, fl(0, 4, 0)};
        settle;
        tick;
        settle;
        check("t4_first_rx", rx_a, 1);
        tick;
        tx_a = 2'b00;
        for (int i = 1; i <= S2 + 2; i++) begin
            tick;
            check("t4_stall", stall_a, (i >= S2));
        end
        check("t4_hold_busy", busy_a, 1);
        check("t4_hold_grant", grant_a, 2'b01);
        tx_a = 2'b01; eop_a = 2'b01; data_a = {32'h0, fl(0, 4, 1)};
        settle;
        check("t4_eop_rx", eop_rx_a, 1);
        tick;
        settle;
        check("t4_clear_stall", stall_a, 0);
        check("t4_clear_busy", busy_a, 0);

        // T5: reset mid-packet while src1 owns, pointer returns to 0
        do_reset;
        tx_a = 2'b01; eop_a = 2'b01; cr_a = 1'b1; data_a = {32'h0, fl(0, 5, 0)};
        settle;
        tick;
        settle;
        check("t5_src0", grant_a, 2'b01);
        tick;
        tx_a = 2'b11; eop_a = 2'b00; data_a = {fl(1, 5, 0), fl(0, 5, 0)};
        settle;
        check("t5_idle", busy_a, 0);
        tick;
        settle;
        check("t5_src1", grant_a, 2'b10);
        tick;
        data_a = {fl(1, 5, 1), fl(0, 5, 1)};
        settle;
        check("t5_flit2", data_rx_a, fl(1, 5, 1));
        rst_n = 1'b0;
        settle;
        check("t5_rst_rx", rx_a, 0);
        check("t5_rst_grant", grant_a, 0);
        check("t5_rst_busy", busy_a, 0);
        check("t5_rst_cr", cr_tx_a, 0);
        tick;
        rst_n = 1'b1;
        settle;
        check("t5_rel_grant", grant_a, 0);
        tick;
        settle;
        check("t5_restart_ptr0", grant_a, 2'b01);

        // T6: 3 sources, src2 owns, src1 then src0 request before its EOP
        do_reset;
        tx_b = 3'b100; cr_b = 1'b1; data_b = {fl(2, 6, 0), fl(1, 6, 0), fl(0, 6, 0)};
        settle;
        tick;
        settle;
        check("t6_src2", grant_b, 3'b100);
        tick;
        tx_b = 3'b110;
        settle;
        check("t6_rx", rx_b, 1);
        tick;
        tx_b = 3'b111; eop_b = 3'b100;
        settle;
        check("t6_eop", eop_rx_b, 1);
        tick;
        tx_b = 3'b011; eop_b = 3'b000;
        settle;
        check("t6_idle", busy_b, 0);
        tick;
        settle;
        check("t6_wrap_src0", grant_b, 3'b001);
        eop_b = 3'b001;
        tick;
        eop_b = 3'b000;
        tick;
        settle;
        check("t6_then_src1", grant_b, 3'b010);

        // Randomized traffic on the 3-source instance against the reference model
        do_reset;
        m_busy = 0; m_own = 0; m_ptr = 0; m_idle = 0;
        for (int s = 0; s < 3; s++) begin
            has_pkt[s] = 0; idx[s] = 0; len[s] = 1; pid[s] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cr_b = ($urandom_range(3) != 0);
            for (int s = 0; s < 3; s++) begin
                if (!has_pkt[s] && $urandom_range(3) == 0) begin
                    has_pkt[s] = 1; len[s] = $urandom_range(1, 4); idx[s] = 0; pid[s]++;
                end
                tx_b[s]  = has_pkt[s] && ($urandom_range(7) < 5);
                eop_b[s] = (idx[s] == len[s] - 1);
                data_b[s*32 +: 32] = tx_b[s] ? {8'(s), 8'(pid[s]), 16'(idx[s])} : $urandom();
            end
            settle;
            e_rx    = m_busy && tx_b[m_own];
            e_eop   = e_rx && eop_b[m_own];
            e_data  = e_rx ? data_b[m_own*32 +: 32] : 32'h0;
            e_cr    = m_busy ? (3'(cr_b) << m_own) : 3'b000;
            e_grant = m_busy ? (3'b001 << m_own) : 3'b000;
            e_stall = m_busy && (m_idle >= S3);
            check("rnd_rx", rx_b, e_rx);
            check("rnd_eop", eop_rx_b, e_eop);
            check("rnd_data", data_rx_b, e_data);
            check("rnd_cr", cr_tx_b, e_cr);
            check("rnd_grant", grant_b, e_grant);
            check("rnd_busy", busy_b, m_busy);
            check("rnd_stall", stall_b, e_stall);
            xfer = e_rx && cr_b;
            if (xfer) begin
                idx[m_own]++;
                if (eop_b[m_own]) has_pkt[m_own] = 0;
            end
            if (!m_busy) begin
                found = 0;
                for (int j = 0; j < 3; j++) begin
                    c = (m_ptr + j) % 3;
                    if (!found && tx_b[c]) begin
                        found = 1; m_busy = 1; m_own = c; m_idle = 0;
                    end
                end
            end else if (xfer && eop_b[m_own]) begin
                m_busy = 0; m_ptr = (m_own + 1) % 3; m_idle = 0;
            end else if (tx_b[m_own]) begin
                m_idle = 0;
            end else if (m_idle < S3) begin
                m_idle++;
            end
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
